// File: rtl/idram_blkmov.sv
// Block-transfer initiator for the 512-byte internal data RAM: forward byte copy
// (LDIR style) or constant fill through the RAM's single synchronous port.
module idram_blkmov #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

    state_t        state_reg;
    logic          mode_reg;
    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [AW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          ce_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] din_reg;

    // The CPU may take the port in the very cycle an access is presented, so
    // hold gates the registered strobes directly instead of waiting a cycle.
    assign mem_ce   = ce_reg & ~hold;
    assign mem_we   = we_reg & ~hold;
    assign mem_addr = addr_reg;
    assign mem_din  = din_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            src_reg   <= '0;
            dst_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ce_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            mode_reg <= mode;
                            src_reg  <= src;
                            dst_reg  <= dst;
                            cnt_reg  <= len;
                            busy_reg <= 1'b1;
                            ce_reg   <= 1'b1;
                            if (mode) begin
                                // Fill keeps the constant in the write-data register for the whole run.
                                state_reg <= WR;
                                we_reg    <= 1'b1;
                                addr_reg  <= dst;
                                din_reg   <= fill_val;
                            end else begin
                                state_reg <= RD;
                                we_reg    <= 1'b0;
                                addr_reg  <= src;
                            end
                        end
                    end
                end
                RD: begin
                    if (!hold) begin
                        // Address stays on src through RDW: the bank mux follows addr[8].
                        state_reg <= RDW;
                        ce_reg    <= 1'b0;
                    end
                end
                RDW: begin
                    state_reg <= WR;
                    din_reg   <= mem_dout;
                    ce_reg    <= 1'b1;
                    we_reg    <= 1'b1;
                    addr_reg  <= dst_reg;
                end
                WR: begin
                    if (!hold) begin
                        src_reg <= src_reg + 1'b1;
                        dst_reg <= dst_reg + 1'b1;
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == AW'(1)) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            ce_reg    <= 1'b0;
                            we_reg    <= 1'b0;
                        end else if (mode_reg) begin
                            addr_reg <= dst_reg + 1'b1;
                        end else begin
                            state_reg <= RD;
                            we_reg    <= 1'b0;
                            addr_reg  <= src_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ce_reg    <= 1'b0;
                    we_reg    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idram_blkmov.sv
// Bench for idram_blkmov: banked RAM model, write scoreboard and latency checks.
module tb_idram_blkmov;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [8:0] src = '0;
    logic [8:0] dst = '0;
    logic [8:0] len = '0;
    logic [7:0] fill_val = '0;
    logic       hold = 1'b0;
    logic       busy, done, mem_ce, mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_din, mem_dout;

    idram_blkmov #(.AW(9), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_val(fill_val), .hold(hold),
        .busy(busy), .done(done), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two 256-byte banks with registered reads; output muxed by the live addr[8].
    logic [7:0] ram [0:511];
    logic [7:0] q0 = '0, q1 = '0;
    logic       pre_we = 1'b0;
    logic [8:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_ce && mem_we) ram[mem_addr] <= mem_din;
        if (mem_ce && !mem_we) begin
            if (mem_addr[8]) q1 <= ram[mem_addr];
            else q0 <= ram[mem_addr];
        end
    end
    assign mem_dout = mem_addr[8] ? q1 : q0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_mem [0:511];
    logic [8:0] exp_a [$];
    logic [7:0] exp_d [$];
    int  ce_cnt = 0;
    bit  rd_pend = 0;
    logic [8:0] rd_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Scoreboard: every RAM write must match the next expected write in order.
    always @(negedge clk) begin
        if (mem_ce) ce_cnt++;
        if (rd_pend) chk("rdw_addr", 32'(mem_addr), 32'(rd_addr));
        rd_pend = mem_ce && !mem_we;
        rd_addr = mem_addr;
        if (mem_ce && mem_we) begin
            if (exp_a.size() == 0) begin
                chk("unexpected_wr", 32'(mem_addr), 32'h1ffff);
            end else begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_a.pop_front()));
                chk("wr_data", 32'(mem_din), 32'(exp_d.pop_front()));
            end
        end
    end

    task automatic preload(input int a, input int d);
        pre_addr = 9'(a);
        pre_data = 8'(d);
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
        exp_mem[a & 511] = 8'(d);
    endtask

    task automatic start_xfer(input bit md, input int s, input int d, input int n,
                              input int fv, input int nwr, output int e);
        for (int i = 0; i < nwr; i++) begin
            int da;
            logic [7:0] v;
            da = (d + i) & 511;
            v  = md ? 8'(fv) : exp_mem[(s + i) & 511];
            exp_mem[da] = v;
            exp_a.push_back(9'(da));
            exp_d.push_back(v);
        end
        @(posedge clk);
        #1;
        mode = md; src = 9'(s); dst = 9'(d); len = 9'(n); fill_val = 8'(fv); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = cyc;
        chk("busy_rise", 32'(busy), 32'(n != 0));
    endtask

    task automatic wait_done(input string name, input int e, input int lat);
        bit seen = 0;
        int d = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                d = cyc;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_latency"}, 32'(d - e), 32'(lat));
            chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        end
        @(negedge clk);
        chk({name, "_done_width"}, 32'(done), 32'd0);
        chk({name, "_pending_wr"}, 32'(exp_a.size()), 32'd0);
        $display("xfer %s: latency %0d cycles (expected %0d)", name, d - e, lat);
    endtask

    task automatic check_ram(input string name, input int a, input int n);
        for (int i = 0; i < n; i++)
            chk(name, 32'(ram[(a + i) & 511]), 32'(exp_mem[(a + i) & 511]));
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_ce"}, 32'(mem_ce), 32'd0);
        chk({name, "_we"}, 32'(mem_we), 32'd0);
        chk({name, "_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_din"}, 32'(mem_din), 32'd0);
    endtask

    initial begin
        int e;
        int c0;
        int nd;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        // Fill 4 bytes of 0xA5 at 0x010.
        for (int i = 0; i < 4; i++) preload(16'h010 + i, 0);
        start_xfer(1, 0, 16'h010, 4, 8'hA5, 4, e);
        wait_done("fill", e, 4);
        check_ram("fill_ram", 16'h010, 4);

        // Copy across the bank boundary.
        preload(16'h0FE, 8'h11); preload(16'h0FF, 8'h22);
        preload(16'h100, 8'h33); preload(16'h101, 8'h44);
        start_xfer(0, 16'h0FE, 16'h180, 4, 0, 4, e);
        wait_done("copy_bank", e, 12);
        check_ram("copy_bank_ram", 16'h180, 4);

        // Source pointer wraps from 0x1FF to 0x000.
        preload(16'h1FF, 8'h77); preload(16'h000, 8'h88);
        start_xfer(0, 16'h1FF, 16'h0F0, 2, 0, 2, e);
        wait_done("wrap", e, 6);
        check_ram("wrap_ram", 16'h0F0, 2);

        // Zero length: immediate done and no RAM access.
        c0 = ce_cnt;
        start_xfer(0, 16'h020, 16'h030, 0, 0, 0, e);
        wait_done("zero_len", e, 0);
        chk("zero_len_ce", 32'(ce_cnt - c0), 32'd0);

        // Copy of 2 bytes with hold high for the first three WR cycles.
        preload(16'h030, 8'hC1); preload(16'h031, 8'hC2);
        start_xfer(0, 16'h030, 16'h060, 2, 0, 2, e);
        repeat (2) begin @(posedge clk); #1; end
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_we", 32'(mem_we), 32'd0);
            chk("hold_ce", 32'(mem_ce), 32'd0);
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        wait_done("hold", e, 9);
        check_ram("hold_ram", 16'h060, 2);

        // Overlapping forward copy replicates 0x5A; a mid-transfer start is ignored.
        preload(16'h020, 8'h5A);
        for (int i = 1; i < 4; i++) preload(16'h020 + i, 8'h00);
        preload(16'h040, 8'h00);
        start_xfer(0, 16'h020, 16'h021, 3, 0, 3, e);
        repeat (4) begin @(posedge clk); #1; end
        mode = 1'b1; dst = 9'h040; len = 9'd1; fill_val = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("overlap", e, 9);
        check_ram("overlap_ram", 16'h020, 4);
        check_ram("ignored_start_ram", 16'h040, 1);

        // Back-to-back: a start sampled in the done cycle is accepted.
        for (int i = 0; i < 2; i++) preload(16'h070 + i, 0);
        for (int i = 0; i < 2; i++) begin
            exp_mem[16'h070 + i] = 8'h3C;
            exp_a.push_back(9'(16'h070 + i));
            exp_d.push_back(8'h3C);
        end
        start_xfer(1, 0, 16'h010, 0, 0, 0, e);
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        mode = 1'b1; dst = 9'h070; len = 9'd2; fill_val = 8'h3C; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b", cyc, 2);
        check_ram("b2b_ram", 16'h070, 2);

        // Reset asserted during the 2nd WR of a 4-byte copy.
        for (int i = 0; i < 4; i++) preload(16'h0A0 + i, i + 1);
        for (int i = 0; i < 4; i++) preload(16'h0B0 + i, 8'hEE);
        start_xfer(0, 16'h0A0, 16'h0B0, 4, 0, 2, e);
        repeat (5) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_reset_no_done", 32'(nd), 32'd0);
        chk("mid_reset_pending_wr", 32'(exp_a.size()), 32'd0);
        check_ram("mid_reset_ram", 16'h0B0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
